// File: rtl/alu_arb_pkg.sv
// Shared widths, opcodes and controller states for the two-port ALU sequencer.
package alu_arb_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned RES_W  = 8;

    localparam logic [OP_W-1:0] OP_OR_RED  = 4'h0;
    localparam logic [OP_W-1:0] OP_AND_RED = 4'h1;
    localparam logic [OP_W-1:0] OP_XOR_RED = 4'h2;
    localparam logic [OP_W-1:0] OP_AND_NZ  = 4'h3;
    localparam logic [OP_W-1:0] OP_OR_NZ   = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR_NZ  = 4'h5;
    localparam logic [OP_W-1:0] OP_GT      = 4'h6;
    localparam logic [OP_W-1:0] OP_LT      = 4'h7;
    localparam logic [OP_W-1:0] OP_EQZ     = 4'h8;
    localparam logic [OP_W-1:0] OP_EQ      = 4'h9;
    localparam logic [OP_W-1:0] OP_ADD     = 4'hA;
    localparam logic [OP_W-1:0] OP_SUB     = 4'hB;
    localparam logic [OP_W-1:0] OP_MUL     = 4'hC;
    localparam logic [OP_W-1:0] OP_SHR     = 4'hD;
    localparam logic [OP_W-1:0] OP_SHL     = 4'hE;
    localparam logic [OP_W-1:0] OP_NOT     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_datapath.sv
// Combinational 4-bit ALU: (op, a, b) -> 8-bit result; unused result bits are zero.
module alu_datapath
    import alu_arb_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [RES_W-1:0]  result
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = {4'b0, a};
    assign b_ext = {4'b0, b};

    always_comb begin
        result = '0;
        case (op)
            OP_OR_RED:  result[0] = |a;
            OP_AND_RED: result[0] = &a;
            OP_XOR_RED: result[0] = ^a;
            OP_AND_NZ:  result[0] = (a & b) != '0;
            OP_OR_NZ:   result[0] = (a | b) != '0;
            OP_XOR_NZ:  result[0] = (a ^ b) != '0;
            OP_GT:      result[0] = a > b;
            OP_LT:      result[0] = a < b;
            OP_EQZ:     result[0] = a == '0;
            OP_EQ:      result[0] = a == b;
            OP_ADD:     result = a_ext + b_ext;
            OP_SUB:     result = {4'b0, a - b};
            OP_MUL:     result = a_ext * b_ext;
            // Shift amounts past the operand width naturally yield zero.
            OP_SHR:     result = {4'b0, a >> b};
            OP_SHL:     result = a_ext << b;
            OP_NOT:     result = {4'b0, ~a};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU datapath between two requesters,
// returning tagged registered results over a valid/ready channel.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_data,
    output logic [7:0]        op_count
);

    state_t state_q, state_d;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              id_q;
    logic              last_grant_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [RES_W-1:0]  rsp_data_q;
    logic [7:0]        op_count_q;

    logic              winner;
    logic              accept;
    logic              rsp_fire;
    logic [RES_W-1:0]  alu_result;

    always_comb begin
        // On a tie the requester that was not served last wins.
        winner = ~last_grant_q;
        if (req_valid == 2'b01) begin
            winner = 1'b0;
        end else if (req_valid == 2'b10) begin
            winner = 1'b1;
        end

        accept    = (state_q == ST_IDLE) && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end

        rsp_fire = rsp_valid_q && rsp_ready;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (rsp_fire) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            op_count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= winner ? req1_op : req0_op;
                a_q  <= winner ? req1_a  : req0_a;
                b_q  <= winner ? req1_b  : req0_b;
                id_q <= winner;
            end
            if (state_q == ST_EXEC) begin
                rsp_data_q  <= alu_result;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end
            if (state_q == ST_RESP && rsp_fire) begin
                rsp_valid_q  <= 1'b0;
                op_count_q   <= op_count_q + 8'd1;
                last_grant_q <= rsp_id_q;
            end
        end
    end

    alu_datapath u_datapath (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level reference checked every cycle
// plus literal expectations on hand-computed results.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_op, req0_a, req0_b;
    logic [3:0] req1_op, req1_a, req1_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic [7:0] op_count;

    int passed = 0;
    int total  = 0;

    alu_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_op   (req0_op),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_op   (req1_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: got no event within bound, required one", name);
    endtask

    // Reference result from the opcode table, in plain integer arithmetic.
    function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
        int r;
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) ones += (a >> i) & 1;
        case (op)
            0:  r = (a != 0) ? 1 : 0;
            1:  r = (a == 15) ? 1 : 0;
            2:  r = ones % 2;
            3:  r = ((a & b) != 0) ? 1 : 0;
            4:  r = ((a | b) != 0) ? 1 : 0;
            5:  r = (a != b) ? 1 : 0;
            6:  r = (a > b) ? 1 : 0;
            7:  r = (a < b) ? 1 : 0;
            8:  r = (a == 0) ? 1 : 0;
            9:  r = (a == b) ? 1 : 0;
            10: r = a + b;
            11: r = (a - b + 16) % 16;
            12: r = a * b;
            13: r = (b >= 4) ? 0 : a / (1 << b);
            14: r = (b >= 8) ? 0 : (a * (1 << b)) % 256;
            default: r = 15 - a;
        endcase
        return r[7:0];
    endfunction

    // Transaction-level model: phase counts cycles since acceptance (0 = free).
    int   m_phase;
    int   m_op, m_a, m_b;
    logic m_id;
    logic m_last;
    int   m_count;

    function automatic logic model_winner(input logic [1:0] v, input logic last);
        if (v == 2'b11) return (last == 1'b1) ? 1'b0 : 1'b1;
        return v[1];
    endfunction

    initial begin
        logic [1:0] e_ready;
        logic       w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0;
                m_last  = 1'b1;
                m_count = 0;
                check("rst_req_ready", req_ready, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_id", rsp_id, 0);
                check("rst_rsp_data", rsp_data, 0);
                check("rst_op_count", op_count, 0);
            end else begin
                e_ready = 2'b00;
                if (m_phase == 0 && req_valid != 2'b00) begin
                    w = model_winner(req_valid, m_last);
                    e_ready[w] = 1'b1;
                end
                check("cyc_req_ready", req_ready, e_ready);
                check("cyc_rsp_valid", rsp_valid, (m_phase == 2) ? 1 : 0);
                if (m_phase == 2) begin
                    check("cyc_rsp_data", rsp_data, ref_alu(m_op, m_a, m_b));
                    check("cyc_rsp_id", rsp_id, m_id);
                end
                check("cyc_op_count", op_count, m_count);
            end
            @(posedge clk);
            if (rst_n) begin
                if (m_phase == 0 && req_valid != 2'b00) begin
                    w    = model_winner(req_valid, m_last);
                    m_id = w;
                    m_op = w ? int'(req1_op) : int'(req0_op);
                    m_a  = w ? int'(req1_a)  : int'(req0_a);
                    m_b  = w ? int'(req1_b)  : int'(req0_b);
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else if (m_phase == 2 && rsp_ready) begin
                    m_count = (m_count + 1) % 256;
                    m_last  = m_id;
                    m_phase = 0;
                end
            end
        end
    end

    task automatic set_cmd(input int port, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b);
        if (port == 0) begin
            req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Returns after the accepting edge (+1), i.e. inside the EXEC cycle.
    task automatic wait_grant(output int id);
        bit found;
        found = 0;
        id = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                found = 1;
                id = req_ready[1] ? 1 : 0;
            end
        end
        if (!found) timeout("grant_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int port, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b);
        int id;
        set_cmd(port, op, a, b);
        req_valid[port] = 1'b1;
        wait_grant(id);
        check("issue_grant", id, port);
        req_valid[port] = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic id, input logic [7:0] data);
        bit found;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                found = 1;
                check({name, "_data"}, rsp_data, data);
                check({name, "_id"}, rsp_id, id);
            end
        end
        if (!found) timeout({name, "_rsp_wait"});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] data, input string name);
        issue(0, op, a, b);
        expect_rsp(name, 1'b0, data);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int id;
        logic [3:0] a;
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        set_cmd(0, 4'h0, 4'h0, 4'h0);
        set_cmd(1, 4'h0, 4'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request; exact latency is pinned by the per-cycle model.
        issue(0, 4'hA, 4'h9, 4'h8);
        @(negedge clk);
        check("single_exec_no_valid", rsp_valid, 0);
        expect_rsp("single", 1'b0, 8'h11);
        check("single_count", op_count, 1);

        // Held tie right after reset alternates 0,1,0,1.
        do_reset();
        set_cmd(0, 4'hC, 4'hF, 4'hF);
        set_cmd(1, 4'hB, 4'h3, 4'h5);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(id);
            check("tie_grant", id, k % 2);
            if (k == 3) req_valid = 2'b00;
            expect_rsp("tie", (k % 2) == 1, (k % 2 == 1) ? 8'h0E : 8'hE1);
        end
        check("tie_count", op_count, 4);

        // Backpressure: result held, no grants while both request.
        rsp_ready = 1'b0;
        issue(0, 4'hE, 4'h1, 4'h7);
        set_cmd(0, 4'h0, 4'h1, 4'h0);
        set_cmd(1, 4'h0, 4'h1, 4'h0);
        req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 8'h80);
            check("bp_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        expect_rsp("bp", 1'b0, 8'h80);
        check("bp_count", op_count, 5);

        // Shift and compare boundaries.
        run(4'hD, 4'hF, 4'h4, 8'h00, "shr_b4");
        run(4'hE, 4'hF, 4'h8, 8'h00, "shl_b8");
        run(4'h6, 4'h5, 4'h5, 8'h00, "gt_equal");
        run(4'h9, 4'h5, 4'h5, 8'h01, "eq_equal");
        run(4'h8, 4'h0, 4'h3, 8'h01, "eqz_zero");

        // Reset during EXEC discards the command and restores last_grant.
        do_reset();
        issue(0, 4'hA, 4'h1, 4'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_exec_valid", rsp_valid, 0);
        check("rst_exec_count", op_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_exec_no_pulse", rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        set_cmd(0, 4'h4, 4'h0, 4'h2);
        set_cmd(1, 4'h7, 4'h2, 4'h3);
        req_valid = 2'b11;
        wait_grant(id);
        check("post_rst_first", id, 0);
        expect_rsp("post_rst_r0", 1'b0, 8'h01);
        wait_grant(id);
        check("post_rst_second", id, 1);
        req_valid = 2'b00;
        expect_rsp("post_rst_r1", 1'b1, 8'h01);

        // Counter wrap over 256 completions.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            a = (i == 255) ? 4'h6 : i[3:0];
            issue(0, 4'hF, a, 4'h0);
            expect_rsp((i == 255) ? "wrap_last" : "wrap", 1'b0, {4'h0, ~a});
            if (i == 254) check("wrap_255", op_count, 255);
        end
        check("wrap_zero", op_count, 0);
        check("wrap_last_lit", rsp_data, 8'h09);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
